// File: rtl/mul_unit.sv
// Radix-2 shift-add multiplier for RV64 MUL/MULH/MULHSU/MULHU; Done follows Start by 65 edges.
// Backpressure: one op in flight, Start is ignored while Busy so upstream must stall on Busy.
module mul_unit #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Start,
  input  logic [1:0]      MulOp,
  input  logic [XLEN-1:0] Operand1,
  input  logic [XLEN-1:0] Operand2,
  input  logic [4:0]      RDIn,
  input  logic            Kill,
  output logic            Busy,
  output logic            Done,
  output logic [XLEN-1:0] Result,
  output logic [4:0]      RDOut,
  output logic            RegWriteOut
);

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX} state_t;

  state_t              state, state_nxt;
  logic [XLEN-1:0]     mcand, mplier;
  logic [2*XLEN-1:0]   acc;
  logic [CNT_W-1:0]    cnt;
  logic                neg;
  logic [1:0]          op_q;

  logic                accept, last_iter, sign1, sign2;
  logic [XLEN-1:0]     mag1, mag2;
  logic [XLEN:0]       sum;
  logic [2*XLEN-1:0]   prod;

  assign accept    = (state == S_IDLE) && Start && !Kill;
  assign last_iter = (cnt == CNT_W'(XLEN-1));

  // Operand1 is unsigned only for MULHU; Operand2 is unsigned for MULHSU and MULHU.
  assign sign1 = (MulOp != OP_MULHU) && Operand1[XLEN-1];
  assign sign2 = !MulOp[1] && Operand2[XLEN-1];
  assign mag1  = sign1 ? (~Operand1 + 1'b1) : Operand1;
  assign mag2  = sign2 ? (~Operand2 + 1'b1) : Operand2;

  // Carry out of the upper-half add is shifted back in, so magnitude 2^63 is safe.
  assign sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, mcand};
  assign prod = neg ? (~acc + 1'b1) : acc;

  assign Busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_BUSY;
      S_BUSY:  if (Kill) state_nxt = S_IDLE;
               else if (last_iter) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand       <= '0;
      mplier      <= '0;
      acc         <= '0;
      cnt         <= '0;
      neg         <= 1'b0;
      op_q        <= '0;
      RDOut       <= '0;
      Result      <= '0;
      Done        <= 1'b0;
      RegWriteOut <= 1'b0;
    end else begin
      Done        <= 1'b0;
      RegWriteOut <= 1'b0;
      if (accept) begin
        mcand  <= mag1;
        mplier <= mag2;
        acc    <= '0;
        cnt    <= '0;
        neg    <= sign1 ^ sign2;
        op_q   <= MulOp;
        RDOut  <= RDIn;
      end else if (state == S_BUSY && !Kill) begin
        if (mplier[0]) acc <= {sum, acc[XLEN-1:1]};
        else           acc <= {1'b0, acc[2*XLEN-1:1]};
        mplier <= {1'b0, mplier[XLEN-1:1]};
        cnt    <= cnt + 1'b1;
      end else if (state == S_FIX && !Kill) begin
        Result      <= (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        Done        <= 1'b1;
        RegWriteOut <= (RDOut != 5'd0);
      end
    end
  end

endmodule
